// File: rtl/param_priority_encoder.sv
// Registered priority encoder with selectable direction, zero/multi-hot flags and a one-deep valid/ready output stage.
// Optional round-robin search order is enabled by defining PRIORITY_ENC_ROUND_ROBIN_EN.
module param_priority_encoder #(
  parameter int WIDTH = 8,
  localparam int YW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [YW-1:0]    y,
  output logic             zero,
  output logic             multi
);

  function automatic logic [YW-1:0] hi_index(input logic [WIDTH-1:0] v);
    logic [YW-1:0] idx;
    idx = {YW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      idx = v[i] ? YW'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [YW-1:0] lo_index(input logic [WIDTH-1:0] v);
    logic [YW-1:0] idx;
    idx = {YW{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx = v[i] ? YW'(i) : idx;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic has_multi(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) != {WIDTH{1'b0}};
  endfunction

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
  function automatic logic [YW-1:0] rr_index(input logic [WIDTH-1:0] v,
                                             input logic [YW-1:0]    start);
    logic [YW-1:0] idx;
    logic          found;
    int            j;
    idx   = {YW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      j     = int'(start) + k;
      j     = (j >= WIDTH) ? j - WIDTH : j;
      idx   = (!found && v[j]) ? YW'(j) : idx;
      found = found | v[j];
    end
    return idx;
  endfunction

  logic [YW-1:0] ptr_r;
`endif

  logic          out_valid_r;
  logic [YW-1:0] y_r;
  logic          zero_r;
  logic          multi_r;
  logic [YW-1:0] y_s;
  logic          zero_s;
  logic          multi_s;
  logic          accept_s;

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = en && in_ready;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign zero      = zero_r;
  assign multi     = multi_r;

  // Encode the presented request vector.
  always_comb begin
    zero_s  = (a == {WIDTH{1'b0}});
    multi_s = has_multi(a);
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
    y_s     = rr_index(a, ptr_r);
`else
    if (mode) begin
      y_s = lo_index(a);
    end else begin
      y_s = hi_index(a);
    end
`endif
  end

  // Output register: load on accept, clear valid on drain, hold during stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      y_r         <= {YW{1'b0}};
      zero_r      <= 1'b0;
      multi_r     <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      y_r         <= y_s;
      zero_r      <= zero_s;
      multi_r     <= multi_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
  // Search pointer advances past the winner; wraps explicitly at WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {YW{1'b0}};
    end else if (accept_s && !zero_s) begin
      ptr_r <= (y_s == YW'(WIDTH - 1)) ? {YW{1'b0}} : y_s + YW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_param_priority_encoder.sv
// Self-checking bench for param_priority_encoder: directed scenarios plus randomized traffic
// compared against an arithmetic reference model (also covers PRIORITY_ENC_ROUND_ROBIN_EN builds).
module tb_param_priority_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] a = 8'h00;
  logic       mode = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, zero, multi;
  logic [2:0] y;

  logic       en5 = 1'b0;
  logic [4:0] a5 = 5'h00;
  logic       mode5 = 1'b0;
  logic       out_ready5 = 1'b1;
  logic       in_ready5, out_valid5, zero5, multi5;
  logic [2:0] y5;

  int vectors = 0;
  int miscompares = 0;

  // reference model state for the 8-bit instance
  bit m_valid = 1'b0;
  int m_y = 0;
  bit m_zero = 1'b0;
  bit m_multi = 1'b0;
  int m_ptr = 0;

  param_priority_encoder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .mode(mode), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero), .multi(multi));

  param_priority_encoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .a(a5), .mode(mode5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_ready(out_ready5), .y(y5), .zero(zero5), .multi(multi5));

  always #5 clk = ~clk;

  function automatic int ref_idx(input int v, input bit m, input int p);
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
    for (int k = 0; k < 8; k++) begin
      if (((v >> ((p + k) % 8)) & 1) == 1) return (p + k) % 8;
    end
    return 0;
`else
    if (v == 0) return 0;
    if (m) return $clog2(v & -v);
    return $clog2(v + 1) - 1;
`endif
  endfunction

  // one clock: model follows the same edge as the DUTs, returns at the falling edge
  task automatic tick();
    int v;
    @(posedge clk);
    v = int'(a);
    if (en && (!m_valid || out_ready)) begin
      m_valid = 1'b1;
      m_y     = ref_idx(v, mode, m_ptr);
      m_zero  = (v == 0);
      m_multi = ($countones(a) >= 2);
      if (v != 0) m_ptr = (m_y + 1) % 8;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (out_valid !== 1'b0 || y !== 3'd0 || zero !== 1'b0 || multi !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset8: got v=%b y=%0d z=%b m=%b ir=%b want 0 0 0 0 1", out_valid, y, zero, multi, in_ready);
    end
    vectors++;
    if (out_valid5 !== 1'b0 || y5 !== 3'd0 || zero5 !== 1'b0 || multi5 !== 1'b0 || in_ready5 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset5: got v=%b y=%0d z=%b m=%b ir=%b want 0 0 0 0 1", out_valid5, y5, zero5, multi5, in_ready5);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_walking();
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; a = 8'h01 << i; mode = 1'b0; out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL walk_in_ready: got %b want 1", in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || y !== 3'(i) || zero !== 1'b0 || multi !== 1'b0) begin
        miscompares++;
        $display("FAIL walk_%0d: got v=%b y=%0d z=%b m=%b want 1 %0d 0 0", i, out_valid, y, zero, multi, i);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    int exp0, exp1;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
    exp0 = 2; exp1 = 5;
`else
    exp0 = 7; exp1 = 2;
`endif
    en = 1'b1; a = 8'b1010_0100; mode = 1'b0;
    tick();
    vectors++;
    if (y !== 3'(exp0) || multi !== 1'b1 || zero !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_mode0: got y=%0d m=%b z=%b v=%b want %0d 1 0 1", y, multi, zero, out_valid, exp0);
    end
    mode = 1'b1;
    tick();
    vectors++;
    if (y !== 3'(exp1) || multi !== 1'b1 || zero !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_mode1: got y=%0d m=%b z=%b v=%b want %0d 1 0 1", y, multi, zero, out_valid, exp1);
    end
    a = 8'h00; mode = 1'b0;
    tick();
    vectors++;
    if (y !== 3'd0 || zero !== 1'b1 || multi !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_zero: got y=%0d z=%b m=%b v=%b want 0 1 0 1", y, zero, multi, out_valid);
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    en = 1'b1; a = 8'h10; mode = 1'b0; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = 8'h01; out_ready = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || y !== 3'd4 || zero !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got v=%b y=%0d z=%b want 1 4 0", i, out_valid, y, zero);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || y !== 3'd0) begin
      miscompares++;
      $display("FAIL bp_no_bubble: got v=%b y=%0d want 1 0", out_valid, y);
    end
    en = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_width5();
    en5 = 1'b1; a5 = 5'b10000; mode5 = 1'b0;
    tick();
    vectors++;
    if (out_valid5 !== 1'b1 || y5 !== 3'd4 || zero5 !== 1'b0 || multi5 !== 1'b0) begin
      miscompares++;
      $display("FAIL w5_top: got v=%b y=%0d z=%b m=%b want 1 4 0 0", out_valid5, y5, zero5, multi5);
    end
    a5 = 5'b00011; mode5 = 1'b1;
    tick();
    vectors++;
    if (out_valid5 !== 1'b1 || y5 !== 3'd0 || multi5 !== 1'b1) begin
      miscompares++;
      $display("FAIL w5_low: got v=%b y=%0d m=%b want 1 0 1", out_valid5, y5, multi5);
    end
    en5 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    en = 1'b1; a = 8'h08; mode = 1'b0; out_ready = 1'b1;
    tick();
    en = 1'b0; out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_ptr = 0;
    vectors++;
    if (out_valid !== 1'b0 || y !== 3'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midstall_reset: got v=%b y=%0d ir=%b want 0 0 1", out_valid, y, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_ready = (i != 1);
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midstall_quiet_%0d: got v=%b want 0", i, out_valid);
      end
    end
    out_ready = 1'b1;
  endtask

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
  task automatic test_round_robin();
    int exp_seq[6] = '{0, 7, 0, 7, 0, 0};
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = (i == 4) ? 8'h00 : 8'h81;
      mode = i[0];
      tick();
      vectors++;
      if (out_valid !== 1'b1 || y !== 3'(exp_seq[i]) || zero !== (i == 4)) begin
        miscompares++;
        $display("FAIL rr_%0d: got v=%b y=%0d z=%b want 1 %0d %b", i, out_valid, y, zero, exp_seq[i], (i == 4));
      end
    end
    en = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(3) != 0);
      a = 8'($urandom & $urandom);
      if ($urandom_range(7) == 0) a = 8'h00;
      mode = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      vectors++;
      if (in_ready !== (!m_valid || out_ready)) begin
        miscompares++;
        $display("FAIL rand_in_ready_%0d: got %b want %b", i, in_ready, (!m_valid || out_ready));
      end
      tick();
      vectors++;
      if (out_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rand_valid_%0d: got %b want %b", i, out_valid, m_valid);
      end else if (m_valid && (y !== 3'(m_y) || zero !== m_zero || multi !== m_multi)) begin
        miscompares++;
        $display("FAIL rand_result_%0d: got y=%0d z=%b m=%b want %0d %b %b", i, y, zero, multi, m_y, m_zero, m_multi);
      end
    end
    en = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_walking();
    test_priority();
    test_backpressure();
    test_width5();
    test_reset_mid_stall();
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
